sirv_wdog_win: RTL and testbench

Parametrised windowed watchdog, the next-generation watchdog peripheral in the always-on domain. It adds a configurable counter width, NCMP comparators with per-comparator interrupts, and windowed feeding, where a feed before the window opens is a violation. Its reset output has two modes: sticky level, or a timed pulse that then re-arms. The register-port interface matches the existing peripheral register-router style: one write_valid/bits pair and one read bus per register.

---
 rtl/sirv_wdog_pkg.sv | 29 ++
 rtl/sirv_wdog_rstgen.sv | 69 ++++++
 rtl/sirv_wdog_win.sv | 212 +++++++++++++++++++++
 tb/tb_sirv_wdog_win.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sirv_wdog_pkg.sv
`default_nettype none
//==============================================================================
// Package : sirv_wdog_pkg
// Shared constants and state encoding for the windowed watchdog.
// Rev     : 1.0
//==============================================================================
package sirv_wdog_pkg;

  // cfg register field positions
  localparam int CFG_SCALE_LSB  = 0;
  localparam int CFG_SCALE_W    = 4;
  localparam int CFG_RSTEN      = 8;
  localparam int CFG_ZEROCMP    = 9;
  localparam int CFG_WINEN      = 10;
  localparam int CFG_PULSEMODE  = 11;
  localparam int CFG_CNT_ALWAYS = 12;
  localparam int CFG_CNT_AWAKE  = 13;
  localparam int CFG_IP_LSB     = 28;

  localparam logic [31:0] KEY  = 32'h0051_F15E;
  localparam logic [31:0] FEED = 32'h0D09_F00D;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } rst_state_e;

endpackage
`default_nettype wire

// File: rtl/sirv_wdog_rstgen.sv
`default_nettype none
//==============================================================================
// Module : sirv_wdog_rstgen
// Reset request generator: sticky level or fixed-length pulse with release.
// Rev    : 1.0
//==============================================================================
module sirv_wdog_rstgen
  import sirv_wdog_pkg::*;
#(
  parameter int RST_PULSE = 32
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_trig,
  input  logic i_pulsemode,
  output logic o_rst,
  output logic o_release
);

  localparam int c_cw = (RST_PULSE > 2) ? $clog2(RST_PULSE) : 1;

  rst_state_e       r_state;
  rst_state_e       w_state_nxt;
  logic [c_cw-1:0]  r_pcnt;
  logic [c_cw-1:0]  w_pcnt_nxt;
  logic             r_sticky;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pcnt   <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      if (i_trig && !i_pulsemode) begin
        r_sticky <= 1'b1;
      end
    end
  end

  // Triggers seen while a pulse is running are deliberately dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    o_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_trig && i_pulsemode) begin
          w_state_nxt = ST_PULSE;
          w_pcnt_nxt  = c_cw'(RST_PULSE - 1);
        end
      end
      ST_PULSE: begin
        if (r_pcnt == '0) begin
          w_state_nxt = ST_IDLE;
          o_release   = 1'b1;
        end else begin
          w_pcnt_nxt = r_pcnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_rst = r_sticky | (r_state == ST_PULSE);

endmodule
`default_nettype wire

// File: rtl/sirv_wdog_win.sv
`default_nettype none
//==============================================================================
// Module : sirv_wdog_win
// Parametrised windowed watchdog with per-comparator interrupts.
// Rev    : 1.0
//==============================================================================
module sirv_wdog_win
  import sirv_wdog_pkg::*;
#(
  parameter int CNT_W     = 31,
  parameter int CMP_W     = 16,
  parameter int NCMP      = 2,
  parameter int RST_PULSE = 32
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   io_regs_cfg_write_valid,
  input  logic [31:0]            io_regs_cfg_write_bits,
  output logic [31:0]            io_regs_cfg_read,
  input  logic                   io_regs_count_write_valid,
  input  logic [CNT_W-1:0]       io_regs_count_write_bits,
  output logic [CNT_W-1:0]       io_regs_count_read,
  output logic [CMP_W-1:0]       io_regs_s_read,
  input  logic [NCMP-1:0]        io_regs_cmp_write_valid,
  input  logic [CMP_W-1:0]       io_regs_cmp_write_bits,
  output logic [NCMP*CMP_W-1:0]  io_regs_cmp_read,
  input  logic                   io_regs_feed_write_valid,
  input  logic [31:0]            io_regs_feed_write_bits,
  output logic [31:0]            io_regs_feed_read,
  input  logic                   io_regs_key_write_valid,
  input  logic [31:0]            io_regs_key_write_bits,
  output logic [31:0]            io_regs_key_read,
  input  logic                   io_regs_cause_write_valid,
  input  logic [1:0]             io_regs_cause_write_bits,
  output logic [31:0]            io_regs_cause_read,
  input  logic                   io_corerst,
  output logic [NCMP-1:0]        io_ip,
  output logic                   io_rst
);

  logic [1:0]                   r_corerst_sync;
  logic [CFG_SCALE_W-1:0]       r_scale;
  logic                         r_rsten;
  logic                         r_zerocmp;
  logic                         r_winen;
  logic                         r_pulsemode;
  logic                         r_count_always;
  logic                         r_count_awake;
  logic [NCMP-1:0]              r_ip;
  logic [CNT_W-1:0]             r_count;
  logic [NCMP-1:0][CMP_W-1:0]   r_cmp;
  logic                         r_unlocked;
  logic [1:0]                   r_cause;

  logic                         w_other_wr;
  logic                         w_cfg_we;
  logic                         w_count_we;
  logic                         w_cause_we;
  logic                         w_feed;
  logic                         w_early;
  logic                         w_count_en;
  logic                         w_count_reset;
  logic                         w_trig;
  logic                         w_release;
  logic [CNT_W-1:0]             w_shifted;
  logic [CMP_W-1:0]             w_s;
  logic [NCMP-1:0]              w_elapsed;
  logic [1:0]                   w_cause_clr;
  logic                         w_unused_bits;

  assign w_other_wr = io_regs_cfg_write_valid | io_regs_count_write_valid |
                      (|io_regs_cmp_write_valid) | io_regs_feed_write_valid |
                      io_regs_cause_write_valid;

  assign w_cfg_we   = r_unlocked & io_regs_cfg_write_valid;
  assign w_count_we = r_unlocked & io_regs_count_write_valid;
  assign w_cause_we = r_unlocked & io_regs_cause_write_valid;
  assign w_feed     = r_unlocked & io_regs_feed_write_valid &
                      (io_regs_feed_write_bits == FEED);

  assign w_shifted = r_count >> r_scale;
  assign w_s       = w_shifted[CMP_W-1:0];

  for (genvar gi = 0; gi < NCMP; gi++) begin : g_elapsed
    assign w_elapsed[gi] = (w_s >= r_cmp[gi]);
  end

  assign w_early       = r_winen & w_feed & ~w_elapsed[1];
  assign w_count_en    = r_count_always | (r_count_awake & ~r_corerst_sync[1]);
  assign w_count_reset = w_feed | (r_zerocmp & w_elapsed[0]) | w_release;
  assign w_trig        = r_rsten & (w_elapsed[0] | w_early);
  assign w_cause_clr   = w_cause_we ? io_regs_cause_write_bits : 2'b00;

  // Only the truncated scaled count is compared; cfg has reserved holes.
  assign w_unused_bits = ^{io_regs_cfg_write_bits, w_shifted[CNT_W-1:CMP_W]};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_corerst_sync <= 2'b00;
    end else begin
      r_corerst_sync <= {r_corerst_sync[0], io_corerst};
    end
  end

  // The key only unlocks when it is the sole register write in its cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_unlocked <= 1'b0;
    end else if (io_regs_key_write_valid && (io_regs_key_write_bits == KEY) && !w_other_wr) begin
      r_unlocked <= 1'b1;
    end else if (io_regs_key_write_valid || w_other_wr) begin
      r_unlocked <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_scale        <= '0;
      r_rsten        <= 1'b0;
      r_zerocmp      <= 1'b0;
      r_winen        <= 1'b0;
      r_pulsemode    <= 1'b0;
      r_count_always <= 1'b0;
      r_count_awake  <= 1'b0;
    end else if (w_cfg_we) begin
      r_scale        <= io_regs_cfg_write_bits[CFG_SCALE_LSB +: CFG_SCALE_W];
      r_rsten        <= io_regs_cfg_write_bits[CFG_RSTEN];
      r_zerocmp      <= io_regs_cfg_write_bits[CFG_ZEROCMP];
      r_winen        <= io_regs_cfg_write_bits[CFG_WINEN];
      r_pulsemode    <= io_regs_cfg_write_bits[CFG_PULSEMODE];
      r_count_always <= io_regs_cfg_write_bits[CFG_CNT_ALWAYS];
      r_count_awake  <= io_regs_cfg_write_bits[CFG_CNT_AWAKE];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ip <= '0;
    end else if (w_cfg_we) begin
      r_ip <= io_regs_cfg_write_bits[CFG_IP_LSB +: NCMP] | w_elapsed;
    end else begin
      r_ip <= r_ip | w_elapsed;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp <= '1;
    end else begin
      for (int i = 0; i < NCMP; i++) begin
        if (r_unlocked && io_regs_cmp_write_valid[i]) begin
          r_cmp[i] <= io_regs_cmp_write_bits;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_count_reset) begin
      r_count <= '0;
    end else if (w_count_we) begin
      r_count <= io_regs_count_write_bits;
    end else begin
      r_count <= r_count + CNT_W'(w_count_en);
    end
  end

  // A new cause event in the same cycle as its clear wins.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cause <= 2'b00;
    end else begin
      r_cause <= (r_cause & ~w_cause_clr) |
                 {r_rsten & w_early, r_rsten & w_elapsed[0]};
    end
  end

  sirv_wdog_rstgen #(
    .RST_PULSE (RST_PULSE)
  ) u_rstgen (
    .clock       (clock),
    .rst_n       (rst_n),
    .i_trig      (w_trig),
    .i_pulsemode (r_pulsemode),
    .o_rst       (io_rst),
    .o_release   (w_release)
  );

  always_comb begin
    io_regs_cfg_read                                  = 32'h0;
    io_regs_cfg_read[CFG_SCALE_LSB +: CFG_SCALE_W]    = r_scale;
    io_regs_cfg_read[CFG_RSTEN]                       = r_rsten;
    io_regs_cfg_read[CFG_ZEROCMP]                     = r_zerocmp;
    io_regs_cfg_read[CFG_WINEN]                       = r_winen;
    io_regs_cfg_read[CFG_PULSEMODE]                   = r_pulsemode;
    io_regs_cfg_read[CFG_CNT_ALWAYS]                  = r_count_always;
    io_regs_cfg_read[CFG_CNT_AWAKE]                   = r_count_awake;
    io_regs_cfg_read[CFG_IP_LSB +: NCMP]              = r_ip;
  end

  assign io_regs_count_read = r_count;
  assign io_regs_s_read     = w_s;
  assign io_regs_cmp_read   = r_cmp;
  assign io_regs_feed_read  = 32'h0;
  assign io_regs_key_read   = {31'b0, r_unlocked};
  assign io_regs_cause_read = {30'b0, r_cause};
  assign io_ip              = r_ip;

endmodule
`default_nettype wire

// File: tb/tb_sirv_wdog_win.sv
`default_nettype none
//==============================================================================
// Module : tb_sirv_wdog_win
// Directed self-checking bench for the windowed watchdog.
// Rev    : 1.0
//==============================================================================
module tb_sirv_wdog_win;

  localparam int CNT_W = 31;
  localparam int CMP_W = 16;
  localparam int NCMP  = 2;
  localparam logic [31:0] c_key  = 32'h0051_F15E;
  localparam logic [31:0] c_feed = 32'h0D09_F00D;
  localparam logic [31:0] c_rsten  = 32'h0000_0100;
  localparam logic [31:0] c_winen  = 32'h0000_0400;
  localparam logic [31:0] c_pulse  = 32'h0000_0800;
  localparam logic [31:0] c_always = 32'h0000_1000;
  localparam logic [31:0] c_awake  = 32'h0000_2000;

  logic                  clock;
  logic                  rst_n;
  logic                  cfg_wv;
  logic [31:0]           cfg_wb;
  logic [31:0]           cfg_rd;
  logic                  count_wv;
  logic [CNT_W-1:0]      count_wb;
  logic [CNT_W-1:0]      count_rd;
  logic [CMP_W-1:0]      s_rd;
  logic [NCMP-1:0]       cmp_wv;
  logic [CMP_W-1:0]      cmp_wb;
  logic [NCMP*CMP_W-1:0] cmp_rd;
  logic                  feed_wv;
  logic [31:0]           feed_wb;
  logic [31:0]           feed_rd;
  logic                  key_wv;
  logic [31:0]           key_wb;
  logic [31:0]           key_rd;
  logic                  cause_wv;
  logic [1:0]            cause_wb;
  logic [31:0]           cause_rd;
  logic                  corerst;
  logic [NCMP-1:0]       ip;
  logic                  wdog_rst;

  int n_assert = 0;
  int n_fail   = 0;

  sirv_wdog_win #(
    .CNT_W(CNT_W), .CMP_W(CMP_W), .NCMP(NCMP), .RST_PULSE(32)
  ) dut (
    .clock                     (clock),
    .rst_n                     (rst_n),
    .io_regs_cfg_write_valid   (cfg_wv),
    .io_regs_cfg_write_bits    (cfg_wb),
    .io_regs_cfg_read          (cfg_rd),
    .io_regs_count_write_valid (count_wv),
    .io_regs_count_write_bits  (count_wb),
    .io_regs_count_read        (count_rd),
    .io_regs_s_read            (s_rd),
    .io_regs_cmp_write_valid   (cmp_wv),
    .io_regs_cmp_write_bits    (cmp_wb),
    .io_regs_cmp_read          (cmp_rd),
    .io_regs_feed_write_valid  (feed_wv),
    .io_regs_feed_write_bits   (feed_wb),
    .io_regs_feed_read         (feed_rd),
    .io_regs_key_write_valid   (key_wv),
    .io_regs_key_write_bits    (key_wb),
    .io_regs_key_read          (key_rd),
    .io_regs_cause_write_valid (cause_wv),
    .io_regs_cause_write_bits  (cause_wb),
    .io_regs_cause_read        (cause_rd),
    .io_corerst                (corerst),
    .io_ip                     (ip),
    .io_rst                    (wdog_rst)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    cfg_wv = 0; count_wv = 0; cmp_wv = '0; feed_wv = 0; key_wv = 0; cause_wv = 0;
    cfg_wb = '0; count_wb = '0; cmp_wb = '0; feed_wb = '0; key_wb = '0; cause_wb = '0;
    corerst = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wr_key();
    key_wv = 1; key_wb = c_key;
    tick();
    key_wv = 0;
  endtask

  task automatic wr_cfg(input logic [31:0] v);
    wr_key();
    cfg_wv = 1; cfg_wb = v;
    tick();
    cfg_wv = 0;
  endtask

  task automatic wr_cmp(input int idx, input logic [CMP_W-1:0] v);
    wr_key();
    cmp_wv = NCMP'(1 << idx); cmp_wb = v;
    tick();
    cmp_wv = '0;
  endtask

  task automatic wr_feed();
    feed_wv = 1; feed_wb = c_feed;
    tick();
    feed_wv = 0;
  endtask

  initial begin
    int hi;
    rst_n = 1;
    do_reset();

    // Reset values
    check("reset_count", 64'(count_rd), 64'h0);
    check("reset_cmp", 64'(cmp_rd), 64'hFFFF_FFFF);
    check("reset_cfg", 64'(cfg_rd), 64'h0);
    check("reset_key", 64'(key_rd), 64'h0);
    check("reset_cause", 64'(cause_rd), 64'h0);
    check("reset_rst", 64'(wdog_rst), 64'h0);
    check("reset_feed_rd", 64'(feed_rd), 64'h0);

    // Locking
    cmp_wv = 2'b01; cmp_wb = 16'd5;
    tick();
    cmp_wv = '0;
    check("lock_cmp_ignored", 64'(cmp_rd), 64'hFFFF_FFFF);
    wr_key();
    check("lock_key_open", 64'(key_rd), 64'h1);
    cmp_wv = 2'b01; cmp_wb = 16'd5;
    tick();
    cmp_wv = '0;
    check("lock_cmp_written", 64'(cmp_rd), 64'hFFFF_0005);
    check("lock_key_closed", 64'(key_rd), 64'h0);

    // Timeout, sticky mode
    do_reset();
    wr_cmp(0, 16'd10);
    wr_cfg(c_always | c_rsten);
    check("to_count0", 64'(count_rd), 64'h0);
    repeat (10) tick();
    check("to_count10", 64'(count_rd), 64'd10);
    check("to_rst_before", 64'(wdog_rst), 64'h0);
    tick();
    check("to_rst", 64'(wdog_rst), 64'h1);
    check("to_ip", 64'(ip), 64'h1);
    check("to_cause", 64'(cause_rd), 64'h1);
    repeat (20) tick();
    check("to_sticky", 64'(wdog_rst), 64'h1);
    rst_n = 0;
    #1;
    check("to_rst_cleared", 64'(wdog_rst), 64'h0);

    // Windowed feed, too early
    do_reset();
    wr_cmp(1, 16'd8);
    wr_cmp(0, 16'd20);
    wr_cfg(c_winen | c_rsten | c_always);
    repeat (3) tick();
    wr_key();
    check("early_s4", 64'(s_rd), 64'd4);
    wr_feed();
    check("early_rst", 64'(wdog_rst), 64'h1);
    check("early_cause", 64'(cause_rd), 64'h2);
    check("early_count0", 64'(count_rd), 64'h0);
    wr_key();
    cause_wv = 1; cause_wb = 2'b10;
    tick();
    cause_wv = 0;
    check("cause_w1c", 64'(cause_rd), 64'h0);
    check("early_still_rst", 64'(wdog_rst), 64'h1);

    // Windowed feed, inside window
    do_reset();
    wr_cmp(1, 16'd8);
    wr_cmp(0, 16'd20);
    wr_cfg(c_winen | c_rsten | c_always);
    repeat (11) tick();
    wr_key();
    check("win_s12", 64'(s_rd), 64'd12);
    wr_feed();
    check("win_count0", 64'(count_rd), 64'h0);
    check("win_no_rst", 64'(wdog_rst), 64'h0);
    check("win_cause", 64'(cause_rd), 64'h0);
    check("win_ip1", 64'(ip), 64'h2);
    tick();
    check("win_count1", 64'(count_rd), 64'h1);

    // Pulse mode
    do_reset();
    wr_cmp(0, 16'd10);
    wr_cfg(c_pulse | c_rsten | c_always);
    repeat (10) tick();
    check("pulse_pre", 64'(wdog_rst), 64'h0);
    tick();
    check("pulse_start", 64'(wdog_rst), 64'h1);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wdog_rst) hi++;
      else break;
    end
    check("pulse_len", 64'(hi), 64'd32);
    check("pulse_count0", 64'(count_rd), 64'h0);
    repeat (10) tick();
    check("pulse2_pre", 64'(wdog_rst), 64'h0);
    tick();
    check("pulse2_start", 64'(wdog_rst), 64'h1);

    // countAwake with core reset
    do_reset();
    wr_cfg(c_awake);
    repeat (5) tick();
    check("awake_count5", 64'(count_rd), 64'd5);
    corerst = 1;
    repeat (2) tick();
    check("awake_count7", 64'(count_rd), 64'd7);
    repeat (5) tick();
    check("awake_frozen", 64'(count_rd), 64'd7);
    corerst = 0;
    repeat (2) tick();
    check("awake_still", 64'(count_rd), 64'd7);
    tick();
    check("awake_resume", 64'(count_rd), 64'd8);

    // Feed and count write together
    do_reset();
    wr_key();
    count_wv = 1; count_wb = 31'd100;
    tick();
    count_wv = 0;
    check("cw_count100", 64'(count_rd), 64'd100);
    wr_key();
    count_wv = 1; count_wb = 31'd55; feed_wv = 1; feed_wb = c_feed;
    tick();
    count_wv = 0; feed_wv = 0;
    check("feed_over_cw", 64'(count_rd), 64'h0);

    // Key and cfg write together while locked
    do_reset();
    key_wv = 1; key_wb = c_key; cfg_wv = 1; cfg_wb = c_always;
    tick();
    key_wv = 0; cfg_wv = 0;
    check("keycfg_locked", 64'(key_rd), 64'h0);
    check("keycfg_cfg", 64'(cfg_rd), 64'h0);

    // Counter wrap
    do_reset();
    wr_cfg(c_always | 32'h0000_000F);
    check("wrap_cfg", 64'(cfg_rd), 64'h0000_100F);
    wr_key();
    count_wv = 1; count_wb = 31'h7FFF_FFFE;
    tick();
    count_wv = 0;
    check("wrap_count_wr", 64'(count_rd), 64'h7FFF_FFFE);
    check("wrap_s", 64'(s_rd), 64'hFFFF);
    repeat (2) tick();
    check("wrap_count0", 64'(count_rd), 64'h0);
    wr_cfg(c_always | 32'h0000_000F);
    check("wrap_ip_reload", 64'(ip), 64'h0);
    repeat (20) tick();
    check("wrap_no_ip", 64'(ip), 64'h0);
    check("wrap_no_rst", 64'(wdog_rst), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
